// File: rtl/lsu_pkg.sv
// Shared definitions for the load-store unit: address map, region and
// width enums, and small helpers for lane handling and decode.
package lsu_pkg;

  // Address map
  localparam logic [31:0] DMEM_BASE    = 32'h0000_2000;
  localparam logic [31:0] DMEM_MASK    = 32'hFFFF_E000;
  localparam logic [31:0] WORD_MASK    = 32'hFFFF_FFFC;
  localparam logic [31:0] HEX_MASK     = 32'hFFFF_FFF8;
  localparam logic [31:0] LEDR_BASE    = 32'h0000_7000;
  localparam logic [31:0] LEDG_BASE    = 32'h0000_7010;
  localparam logic [31:0] HEX_BASE     = 32'h0000_7020;
  localparam logic [31:0] LCD_BASE     = 32'h0000_7030;
  localparam logic [31:0] SW_BASE      = 32'h0000_7800;
  localparam logic [31:0] BTN_BASE     = 32'h0000_7810;

  // Each HEX byte only carries 7 segment bits; bit 7 of every byte is dropped.
  localparam logic [31:0] HEX_SEG_MASK = 32'h7F7F_7F7F;

  typedef enum logic [2:0] {
    REGION_DMEM = 3'd0,
    REGION_LEDR = 3'd1,
    REGION_LEDG = 3'd2,
    REGION_HEX  = 3'd3,
    REGION_LCD  = 3'd4,
    REGION_SW   = 3'd5,
    REGION_BTN  = 3'd6,
    REGION_NONE = 3'd7
  } mem_region_e;

  typedef enum logic [1:0] {
    WIDTH_BYTE = 2'd0,
    WIDTH_HALF = 2'd1,
    WIDTH_WORD = 2'd2
  } mem_width_e;

  // Map a byte address onto the region that owns it.
  function automatic mem_region_e decode_region(input logic [31:0] addr);
    mem_region_e region;
    if ((addr & DMEM_MASK) == DMEM_BASE) begin
      region = REGION_DMEM;
    end else if ((addr & WORD_MASK) == LEDR_BASE) begin
      region = REGION_LEDR;
    end else if ((addr & WORD_MASK) == LEDG_BASE) begin
      region = REGION_LEDG;
    end else if ((addr & HEX_MASK) == HEX_BASE) begin
      region = REGION_HEX;
    end else if ((addr & WORD_MASK) == LCD_BASE) begin
      region = REGION_LCD;
    end else if ((addr & WORD_MASK) == SW_BASE) begin
      region = REGION_SW;
    end else if ((addr & WORD_MASK) == BTN_BASE) begin
      region = REGION_BTN;
    end else begin
      region = REGION_NONE;
    end
    return region;
  endfunction

  // Natural alignment check for an access of the given width.
  function automatic logic is_misaligned(input mem_width_e width, input logic [1:0] lane);
    logic mis;
    case (width)
      WIDTH_BYTE: mis = 1'b0;
      WIDTH_HALF: mis = lane[0];
      WIDTH_WORD: mis = lane[1] | lane[0];
      default:    mis = 1'b1;
    endcase
    return mis;
  endfunction

  // Byte-write enables for an access of the given width at the given lane.
  function automatic logic [3:0] byte_enable(input mem_width_e width, input logic [1:0] lane);
    logic [3:0] be;
    case (width)
      WIDTH_BYTE: be = 4'b0001 << lane;
      WIDTH_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      WIDTH_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate narrow store data into every lane so the byte enables pick it up.
  function automatic logic [31:0] lane_data(input mem_width_e width, input logic [31:0] data);
    logic [31:0] wide;
    case (width)
      WIDTH_BYTE: wide = {4{data[7:0]}};
      WIDTH_HALF: wide = {2{data[15:0]}};
      WIDTH_WORD: wide = data;
      default:    wide = data;
    endcase
    return wide;
  endfunction

  // Byte-wise merge of new data into an existing word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
    logic [31:0] merged;
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = be[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/lsu_dmem.sv
// Data memory: WORDS x 32 array, per-byte write enables, asynchronous read,
// no reset (contents survive a core reset).
module lsu_dmem
  import lsu_pkg::*;
#(
  parameter int WORDS = 2048,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk_i,
  input  logic [AW-1:0] index_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_r [WORDS];

  // Byte-masked write of the addressed word on the rising edge.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (be_i[b]) begin
        mem_r[index_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end else begin
        mem_r[index_i][8*b +: 8] <= mem_r[index_i][8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_r[index_i];

endmodule

// File: rtl/lsu.sv
// Load-store unit for the single-cycle RV32I core: address decode, byte-lane
// handling, load extension, peripheral registers and input synchronizers.
module lsu
  import lsu_pkg::*;
#(
  parameter int DMEM_WORDS = 2048
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] st_data_i,
  input  logic        mem_wren_i,
  input  logic        sb_en_i,
  input  logic        sh_en_i,
  input  logic        sw_en_i,
  input  logic        lb_en_i,
  input  logic        lh_en_i,
  input  logic        lw_en_i,
  input  logic        lbu_en_i,
  input  logic        lhu_en_i,
  input  logic [31:0] io_sw_i,
  input  logic [3:0]  io_btn_i,
  output logic [31:0] ld_data_o,
  output logic        misaligned_o,
  output logic [31:0] io_ledr_o,
  output logic [31:0] io_ledg_o,
  output logic [55:0] io_hex_o,
  output logic [31:0] io_lcd_o
);

  localparam int DMEM_AW = $clog2(DMEM_WORDS);

  mem_region_e region_s;
  mem_width_e  st_width_s;
  mem_width_e  ld_width_s;
  logic        st_onehot_s;
  logic        ld_onehot_s;
  logic        ld_signed_s;
  logic        store_active_s;
  logic        st_mis_s;
  logic        ld_mis_s;
  logic        commit_s;
  logic [3:0]  be_s;
  logic [3:0]  dmem_be_s;
  logic [31:0] wdata_s;
  logic [31:0] dmem_rdata_s;
  logic [31:0] ld_word_s;
  logic [7:0]  ld_byte_s;
  logic [15:0] ld_half_s;
  logic [31:0] ld_data_s;

  logic [31:0] ledr_r;
  logic [31:0] ledg_r;
  logic [31:0] hex_lo_r;
  logic [31:0] hex_hi_r;
  logic [31:0] lcd_r;
  logic [31:0] sw_meta_r;
  logic [31:0] sw_sync_r;
  logic [3:0]  btn_meta_r;
  logic [3:0]  btn_sync_r;

  assign region_s = decode_region(addr_i);

  // Store width from the one-hot store enables; anything else is no store.
  always_comb begin
    st_width_s  = WIDTH_WORD;
    st_onehot_s = 1'b0;
    case ({sb_en_i, sh_en_i, sw_en_i})
      3'b100: begin st_width_s = WIDTH_BYTE; st_onehot_s = 1'b1; end
      3'b010: begin st_width_s = WIDTH_HALF; st_onehot_s = 1'b1; end
      3'b001: begin st_width_s = WIDTH_WORD; st_onehot_s = 1'b1; end
      default: begin st_width_s = WIDTH_WORD; st_onehot_s = 1'b0; end
    endcase
  end

  // Load width and signedness from the one-hot load enables.
  always_comb begin
    ld_width_s  = WIDTH_WORD;
    ld_signed_s = 1'b0;
    ld_onehot_s = 1'b0;
    case ({lb_en_i, lh_en_i, lw_en_i, lbu_en_i, lhu_en_i})
      5'b10000: begin ld_width_s = WIDTH_BYTE; ld_signed_s = 1'b1; ld_onehot_s = 1'b1; end
      5'b01000: begin ld_width_s = WIDTH_HALF; ld_signed_s = 1'b1; ld_onehot_s = 1'b1; end
      5'b00100: begin ld_width_s = WIDTH_WORD; ld_signed_s = 1'b0; ld_onehot_s = 1'b1; end
      5'b00010: begin ld_width_s = WIDTH_BYTE; ld_signed_s = 1'b0; ld_onehot_s = 1'b1; end
      5'b00001: begin ld_width_s = WIDTH_HALF; ld_signed_s = 1'b0; ld_onehot_s = 1'b1; end
      default:  begin ld_width_s = WIDTH_WORD; ld_signed_s = 1'b0; ld_onehot_s = 1'b0; end
    endcase
  end

  // Alignment, commit qualification and byte-enable generation for stores.
  always_comb begin
    store_active_s = mem_wren_i & st_onehot_s;
    st_mis_s       = store_active_s & is_misaligned(st_width_s, addr_i[1:0]);
    ld_mis_s       = ld_onehot_s & is_misaligned(ld_width_s, addr_i[1:0]);
    commit_s       = store_active_s & ~st_mis_s & ~rst_i;
    wdata_s        = lane_data(st_width_s, st_data_i);
    if (commit_s) begin
      be_s = byte_enable(st_width_s, addr_i[1:0]);
    end else begin
      be_s = 4'b0000;
    end
    if (region_s == REGION_DMEM) begin
      dmem_be_s = be_s;
    end else begin
      dmem_be_s = 4'b0000;
    end
  end

  assign misaligned_o = st_mis_s | ld_mis_s;

  lsu_dmem #(
    .WORDS (DMEM_WORDS),
    .AW    (DMEM_AW)
  ) u_dmem (
    .clk_i   (clk_i),
    .index_i (addr_i[DMEM_AW+1:2]),
    .be_i    (dmem_be_s),
    .wdata_i (wdata_s),
    .rdata_o (dmem_rdata_s)
  );

  // Peripheral registers: byte-masked writes, cleared by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ledr_r   <= 32'd0;
      ledg_r   <= 32'd0;
      hex_lo_r <= 32'd0;
      hex_hi_r <= 32'd0;
      lcd_r    <= 32'd0;
    end else begin
      case (region_s)
        REGION_LEDR: ledr_r <= merge_bytes(ledr_r, wdata_s, be_s);
        REGION_LEDG: ledg_r <= merge_bytes(ledg_r, wdata_s, be_s);
        REGION_LCD:  lcd_r  <= merge_bytes(lcd_r, wdata_s, be_s);
        REGION_HEX: begin
          if (addr_i[2]) begin
            hex_hi_r <= merge_bytes(hex_hi_r, wdata_s & HEX_SEG_MASK, be_s);
          end else begin
            hex_lo_r <= merge_bytes(hex_lo_r, wdata_s & HEX_SEG_MASK, be_s);
          end
        end
        default: begin
          ledr_r <= ledr_r;
        end
      endcase
    end
  end

  // Two-flop synchronizers for the asynchronous board inputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sw_meta_r  <= 32'd0;
      sw_sync_r  <= 32'd0;
      btn_meta_r <= 4'd0;
      btn_sync_r <= 4'd0;
    end else begin
      sw_meta_r  <= io_sw_i;
      sw_sync_r  <= sw_meta_r;
      btn_meta_r <= io_btn_i;
      btn_sync_r <= btn_meta_r;
    end
  end

  // Select the addressed word from whichever region owns the address.
  always_comb begin
    ld_word_s = 32'd0;
    case (region_s)
      REGION_DMEM: ld_word_s = dmem_rdata_s;
      REGION_LEDR: ld_word_s = ledr_r;
      REGION_LEDG: ld_word_s = ledg_r;
      REGION_HEX:  ld_word_s = addr_i[2] ? hex_hi_r : hex_lo_r;
      REGION_LCD:  ld_word_s = lcd_r;
      REGION_SW:   ld_word_s = sw_sync_r;
      REGION_BTN:  ld_word_s = {28'd0, btn_sync_r};
      default:     ld_word_s = 32'd0;
    endcase
  end

  // Lane extraction and sign/zero extension of the load result.
  always_comb begin
    ld_data_s = 32'd0;
    case (addr_i[1:0])
      2'd0:    ld_byte_s = ld_word_s[7:0];
      2'd1:    ld_byte_s = ld_word_s[15:8];
      2'd2:    ld_byte_s = ld_word_s[23:16];
      2'd3:    ld_byte_s = ld_word_s[31:24];
      default: ld_byte_s = 8'd0;
    endcase
    if (addr_i[1]) begin
      ld_half_s = ld_word_s[31:16];
    end else begin
      ld_half_s = ld_word_s[15:0];
    end
    if (ld_onehot_s && !misaligned_o) begin
      case (ld_width_s)
        WIDTH_BYTE: ld_data_s = {{24{ld_signed_s & ld_byte_s[7]}}, ld_byte_s};
        WIDTH_HALF: ld_data_s = {{16{ld_signed_s & ld_half_s[15]}}, ld_half_s};
        WIDTH_WORD: ld_data_s = ld_word_s;
        default:    ld_data_s = 32'd0;
      endcase
    end else begin
      ld_data_s = 32'd0;
    end
  end

  assign ld_data_o = ld_data_s;
  assign io_ledr_o = ledr_r;
  assign io_ledg_o = ledg_r;
  assign io_lcd_o  = lcd_r;
  assign io_hex_o  = {hex_hi_r[30:24], hex_hi_r[22:16], hex_hi_r[14:8], hex_hi_r[6:0],
                      hex_lo_r[30:24], hex_lo_r[22:16], hex_lo_r[14:8], hex_lo_r[6:0]};

endmodule
